// File: rtl/fp16_fix_bank_if.sv
// fp16_fix_bank_if: start/busy/done handshake plus the float16 input and
// fixed-point result buses of fp16_fix_bank. The master modport is the
// requester (processor side), the slave modport is the converter.
interface fp16_fix_bank_if #(
  parameter int unsigned CHANNELS = 10,
  parameter int unsigned FIX_W    = 16
);
  logic                      start;
  logic [CHANNELS*16-1:0]    fp_in;
  logic                      busy;
  logic                      done;
  logic [CHANNELS*FIX_W-1:0] fix_out;
  logic [CHANNELS-1:0]       ovf;

  modport master (
    output start, fp_in,
    input  busy, done, fix_out, ovf
  );

  modport slave (
    input  start, fp_in,
    output busy, done, fix_out, ovf
  );
endinterface

// File: rtl/fp16_fix_bank.sv
// fp16_fix_bank: multi-channel float16 -> signed fixed-point converter.
// One 2-stage pipeline (decode, scale/round) is shared by all channels; a
// start request snapshots every input and done flags a coherent result set.
// Optional macro FP16_FIX_SAT_EN: finite overflow saturates instead of wrapping.
module fp16_fix_bank #(
  parameter int unsigned CHANNELS = 10,
  parameter int unsigned FIX_W    = 16,
  parameter int unsigned FRAC_W   = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  fp16_fix_bank_if.slave    bus
);

  localparam int unsigned IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // 11-bit significand, left shift up to 5+FRAC_W, one guard bit for rounding
  localparam int unsigned MAG_RAW = 17 + FRAC_W;
  localparam int unsigned MAG_W   = (MAG_RAW > FIX_W + 1) ? MAG_RAW : FIX_W + 1;
  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'((64'(1) << (FIX_W - 1)) - 64'(1));
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(64'(1) << (FIX_W - 1));
  localparam logic [FIX_W-1:0] FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W-1:0] FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [CHANNELS*16-1:0]    snap;
  logic                      busy_q;
  logic                      done_q;
  logic [CHANNELS*FIX_W-1:0] fix_q;
  logic [CHANNELS-1:0]       ovf_q;

  // stage 1 (decoded operand) registers
  logic                      s1_valid;
  logic [IDX_W-1:0]          s1_idx;
  logic                      s1_sign;
  logic [4:0]                s1_exp;
  logic [10:0]               s1_sig;
  logic                      s1_inf;
  logic                      s1_nan;

  // decode of the snapshot entry being issued this cycle
  logic [15:0]               dec_fp_c;
  logic [4:0]                dec_exp_c;
  logic [10:0]               dec_sig_c;
  logic                      dec_inf_c;
  logic                      dec_nan_c;

  // stage 2 combinational result
  int                        sh_c;
  int                        rs_c;
  logic [MAG_W-1:0]          mag_c;
  logic [MAG_W-1:0]          sval_c;
  logic [FIX_W-1:0]          res_c;
  logic                      ovf_c;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fix_out = fix_q;
  assign bus.ovf     = ovf_q;

  // Stage-1 decode: subnormals use exponent 1 with a hidden zero bit
  always_comb begin
    dec_fp_c  = snap[idx*16 +: 16];
    dec_exp_c = (dec_fp_c[14:10] == 5'd0) ? 5'd1 : dec_fp_c[14:10];
    dec_sig_c = {(dec_fp_c[14:10] != 5'd0), dec_fp_c[9:0]};
    dec_inf_c = (dec_fp_c[14:10] == 5'd31) && (dec_fp_c[9:0] == 10'd0);
    dec_nan_c = (dec_fp_c[14:10] == 5'd31) && (dec_fp_c[9:0] != 10'd0);
  end

  // Stage-2 scale, round half away from zero, sign and range handling
  always_comb begin
    sh_c   = int'(s1_exp) - 25 + int'(FRAC_W);
    rs_c   = 0;
    mag_c  = '0;
    sval_c = '0;
    res_c  = '0;
    ovf_c  = 1'b0;
    if (sh_c >= 0) begin
      mag_c = MAG_W'(s1_sig) << sh_c;
    end else begin
      rs_c  = -sh_c;
      mag_c = (MAG_W'(s1_sig) + (MAG_W'(1) << (rs_c - 1))) >> rs_c;
    end
    sval_c = s1_sign ? (~mag_c + MAG_W'(1)) : mag_c;
    if (s1_nan) begin
      res_c = '0;
      ovf_c = 1'b0;
    end else if (s1_inf) begin
      res_c = s1_sign ? FIX_MIN : FIX_MAX;
      ovf_c = 1'b1;
    end else begin
      ovf_c = s1_sign ? (mag_c > NEG_LIM) : (mag_c > POS_LIM);
      res_c = sval_c[FIX_W-1:0];
`ifdef FP16_FIX_SAT_EN
      if (ovf_c) begin
        res_c = s1_sign ? FIX_MIN : FIX_MAX;
      end
`endif
    end
  end

  // Control FSM, snapshot capture, pipeline registers and result write-back
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= IDLE;
      idx      <= '0;
      snap     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fix_q    <= '0;
      ovf_q    <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_sig   <= '0;
      s1_inf   <= 1'b0;
      s1_nan   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      s1_valid <= 1'b0;

      if (s1_valid) begin
        fix_q[s1_idx*FIX_W +: FIX_W] <= res_c;
        ovf_q[s1_idx]                <= ovf_c;
      end

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            snap   <= bus.fp_in;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          s1_valid <= 1'b1;
          s1_idx   <= idx;
          s1_sign  <= dec_fp_c[15];
          s1_exp   <= dec_exp_c;
          s1_sig   <= dec_sig_c;
          s1_inf   <= dec_inf_c;
          s1_nan   <= dec_nan_c;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_fix_bank.sv
// tb_fp16_fix_bank: table-driven directed test of fp16_fix_bank at default
// parameters, plus handshake, back-to-back and mid-run reset sequences.
module tb_fp16_fix_bank;

  localparam int unsigned CH     = 10;
  localparam int unsigned FIX_W  = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned NVEC   = 20;
  localparam int unsigned LAT    = CH + 1;

  typedef struct {
    logic [15:0] fp;
    logic [15:0] fix;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst;
  vec_t vec [NVEC];
  int   checks;
  int   errors;

  fp16_fix_bank_if #(.CHANNELS(CH), .FIX_W(FIX_W)) bus ();

  fp16_fix_bank #(.CHANNELS(CH), .FIX_W(FIX_W), .FRAC_W(FRAC_W)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base);
    for (int c = 0; c < CH; c++) bus.fp_in[c*16 +: 16] = vec[base + c].fp;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int c = 0; c < CH; c++) bus.fp_in[c*16 +: 16] = v;
  endtask

  // raise start for one edge; returns #1 after the sampling edge
  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) bcyc++;
      step();
      lat++;
    end
  endtask

  task automatic check_results(input int base, input string tag);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s_fix%0d", tag, c), 64'(bus.fix_out[c*FIX_W +: FIX_W]), 64'(vec[base + c].fix));
      chk($sformatf("%s_ovf%0d", tag, c), 64'(bus.ovf[c]), 64'(vec[base + c].ovf));
    end
  endtask

  initial begin
    int lat;
    int bcyc;
    int extra;
    int dcnt;

    checks = 0;
    errors = 0;

    vec[0]  = '{16'h3C00, 16'h0100, 1'b0};
    vec[1]  = '{16'hC000, 16'hFE00, 1'b0};
    vec[2]  = '{16'h0000, 16'h0000, 1'b0};
    vec[3]  = '{16'h3555, 16'h0055, 1'b0};
    vec[4]  = '{16'h1C00, 16'h0001, 1'b0};
    vec[5]  = '{16'h1800, 16'h0001, 1'b0};
    vec[6]  = '{16'h9800, 16'hFFFF, 1'b0};
    vec[7]  = '{16'h1400, 16'h0000, 1'b0};
    vec[8]  = '{16'h0001, 16'h0000, 1'b0};
`ifdef FP16_FIX_SAT_EN
    vec[9]  = '{16'h5800, 16'h7FFF, 1'b1};
    vec[19] = '{16'hD801, 16'h8000, 1'b1};
`else
    vec[9]  = '{16'h5800, 16'h8000, 1'b1};
    vec[19] = '{16'hD801, 16'h7FE0, 1'b1};
`endif
    vec[10] = '{16'hD800, 16'h8000, 1'b0};
    vec[11] = '{16'h7C00, 16'h7FFF, 1'b1};
    vec[12] = '{16'hFC00, 16'h8000, 1'b1};
    vec[13] = '{16'h7E00, 16'h0000, 1'b0};
    vec[14] = '{16'h8000, 16'h0000, 1'b0};
    vec[15] = '{16'h57FF, 16'h7FF0, 1'b0};
    vec[16] = '{16'h1A00, 16'h0001, 1'b0};
    vec[17] = '{16'h9C00, 16'hFFFF, 1'b0};
    vec[18] = '{16'h4900, 16'h0A00, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.fp_in = '0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_fix",  64'(|bus.fix_out), 64'd0);
    chk("rst_ovf",  64'(|bus.ovf), 64'd0);

    // run A: basic values, rounding, overflow
    load(0);
    pulse_start();
    chk("a_busy_start", 64'(bus.busy), 64'd1);
    wait_done(lat, bcyc);
    chk("a_latency", 64'(lat), 64'(LAT));
    chk("a_busy_cycles", 64'(bcyc), 64'(LAT));
    chk("a_busy_in_done", 64'(bus.busy), 64'd0);
    check_results(0, "a");
    step();
    chk("a_done_pulse", 64'(bus.done), 64'd0);

    // run B: specials; input changed and start re-raised while busy
    load(10);
    pulse_start();
    step();
    step();
    fill(16'h3C00);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(extra, bcyc);
    chk("b_latency", 64'(extra + 3), 64'(LAT));
    check_results(10, "b");
    step();
    chk("b_no_restart_busy", 64'(bus.busy), 64'd0);
    chk("b_no_restart_done", 64'(bus.done), 64'd0);

    // back-to-back: start asserted in the done cycle
    load(0);
    pulse_start();
    wait_done(lat, bcyc);
    chk("bb1_latency", 64'(lat), 64'(LAT));
    load(10);
    pulse_start();
    chk("bb2_busy", 64'(bus.busy), 64'd1);
    chk("bb2_done_low", 64'(bus.done), 64'd0);
    wait_done(lat, bcyc);
    chk("bb2_latency", 64'(lat), 64'(LAT));
    check_results(10, "bb2");

    // reset five cycles into a run
    load(0);
    pulse_start();
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", 64'(bus.busy), 64'd0);
    chk("mr_done", 64'(bus.done), 64'd0);
    chk("mr_fix",  64'(|bus.fix_out), 64'd0);
    chk("mr_ovf",  64'(|bus.ovf), 64'd0);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done || bus.busy) dcnt++;
      step();
    end
    chk("mr_no_done", 64'(dcnt), 64'd0);
    load(10);
    pulse_start();
    wait_done(lat, bcyc);
    chk("mr_after_latency", 64'(lat), 64'(LAT));
    check_results(10, "mr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp16_fix_bank.md
# fp16_fix_bank

Parametrised multi-channel converter from IEEE-754 half-precision to signed fixed-point. It sits between the Nios II PIO exports and the fabric datapath, so the processor writes raw float16 channel values and the NN logic reads fixed-point results. One shared 2-stage conversion pipeline is time-multiplexed across all channels. A start/busy/done handshake provides a coherent snapshot.

## Interface
Parameters:
- CHANNELS, 10, number of channels (1..32)
- FIX_W, 16, fixed-point output width (8..32)
- FRAC_W, 8, fractional bits of output (0..FIX_W-1)

Ports:
- clk_clk  in  1  system clock; the only clock in the block
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  request conversion of all channels; sampled only in IDLE
- fp_in  in  CHANNELS*16  float16 inputs; channel i at [16i+15:16i]
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse: all fix_out/ovf are coherent
- fix_out  out  CHANNELS*FIX_W  two's-complement results; channel i at [FIX_W*i+FIX_W-1:FIX_W*i]
- ovf  out  CHANNELS  per-channel out-of-range flag (see Configuration)

## Operation
- FSM states: IDLE, CONV, DRAIN.
  - IDLE + start: capture fp_in into the snapshot register, clear idx, go to CONV.
  - CONV: issue snapshot[idx] into stage 1 each cycle, then idx++. After issuing idx = CHANNELS-1, go to DRAIN.
  - DRAIN: one cycle for stage 2 to write the last channel. Then go to IDLE and pulse done.
- Changes on fp_in after capture do not affect the run.
- start is ignored while busy is high.
- Stage 1 (decode) extracts sign s, exponent e and mantissa m:
  - Normal (e = 1..30): significand = {1,m}.
  - Subnormal (e = 0): significand = {0,m}, and e is treated as 1.
  - e = 31: flagged as special.
- Stage 2 (scale and round):
  - shift = e - 25 + FRAC_W.
  - shift >= 0: left-shift the significand.
  - shift < 0: right-shift the significand, rounding half away from zero on the magnitude.
  - Then negate if s = 1, and write fix_out[idx] and ovf[idx].
- Internal magnitude width is wide enough that no bit is lost before the range check.
- Range:
  - Positive limit: 2^(FIX_W-1)-1.
  - Negative limit: -2^(FIX_W-1).
  - A rounded result beyond either limit is an overflow.
- Specials, independent of the macro:
  - +Inf gives max positive, -Inf gives min negative, NaN gives 0.
  - ovf = 1 for Inf and 0 for NaN.
- ±0 gives 0.
- ovf[i] is rewritten on every run (not sticky across runs).
- fix_out[i] holds its previous value until channel i is rewritten. Readers must wait for done.

## Timing
- Reset values: busy = 0, done = 0, fix_out = 0, ovf = 0, FSM = IDLE, idx = 0.
- start is sampled at edge E0. busy is high in the cycles after E0 through edge E(CHANNELS+1).
- Channel i is written at edge E(i+2); the last channel is written at edge E(CHANNELS+1).
- done is high for exactly the one cycle following edge E(CHANNELS+1), with busy = 0 in that cycle.
- Start-to-done latency is CHANNELS+1 cycles (11 at default).
- In the done cycle the FSM is already IDLE, so a start asserted then is accepted. Back-to-back runs take CHANNELS+1 cycles each.
- reset_reset high on any edge, including mid-run, forces the reset values on that edge and discards in-flight data.

## Configuration
- FP16_FIX_SAT_EN defined:
  - Finite overflow clamps to the positive or negative limit.
  - ovf[i] = 1.
- FP16_FIX_SAT_EN undefined:
  - Finite overflow wraps: fix_out takes the low FIX_W bits of the exact rounded two's-complement result.
  - ovf[i] still reports the overflow. Inf/NaN handling is unchanged.

## Test plan
All scenarios use defaults: CHANNELS = 10, FIX_W = 16, FRAC_W = 8.
- Basic values: ch0..3 = 0x3C00, 0xC000, 0x0000, 0x3555 -> fix_out = 0x0100, 0xFE00, 0x0000, 0x0055; ovf = 0.
- Rounding: 0x1C00 -> 0x0001; 0x1800 (half LSB) -> 0x0001; 0x9800 -> 0xFFFF; 0x1400 -> 0x0000; subnormal 0x0001 -> 0x0000.
- Range and specials:
  - 0x5800 (128.0) -> 0x7FFF with ovf = 1 under FP16_FIX_SAT_EN; 0x8000 with ovf = 1 without it.
  - 0xD800 -> 0x8000 with ovf = 0.
  - 0x7C00 -> 0x7FFF with ovf = 1; 0xFC00 -> 0x8000 with ovf = 1; 0x7E00 -> 0x0000 with ovf = 0.
- Handshake:
  - A start pulse produces done exactly 11 cycles later, with busy high for 11 cycles.
  - A start during busy is ignored.
  - Changing fp_in 2 cycles after start leaves the results unchanged.
  - A start in the done cycle begins a second run; its done comes 11 cycles later.
- Reset mid-run: assert reset_reset 5 cycles after start -> all outputs 0 on the next cycle and no done pulse. A following start completes normally.
